unsigned_mul_8x8_ha_array_accum: RTL and testbench

// - Consumer end of the 8x8 unsigned half-adder-array partial-product interface.
// - Takes the four compressed rows ha_array_{0..3}_{b,t} from one multiply.
// - Weights and sums the rows into the final product.
// - Two-stage valid/ready pipeline between the approximate HA-array front end and

---
 rtl/mul8x8_ha_pkg.sv | 17 +
 rtl/mul8x8_ha_pipe_stage.sv | 46 ++++
 rtl/unsigned_mul_8x8_ha_array_accum.sv | 103 ++++++++++
 tb/tb_unsigned_mul_8x8_ha_array_accum.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul8x8_ha_pkg.sv
// rtl/mul8x8_ha_pkg.sv - shared widths and row weighting for the 8x8 HA-array accumulator
// Row widths follow the half-adder array front end; PART_W holds R_a + 4*R_b without wrap.
package mul8x8_ha_pkg;

   localparam int HA_B_W  = 7;
   localparam int HA_T_W  = 9;
   localparam int HA_ROWS = 4;
   localparam int ROW_W   = 10;
   localparam int PART_W  = 13;
   localparam int SUM_W   = 17;

   function automatic logic [ROW_W-1:0] row_val(input logic [HA_B_W-1:0] b,
                                                 input logic [HA_T_W-1:0] t);
      return ROW_W'(t) + (ROW_W'(b) << 2);
   endfunction

endpackage

// File: rtl/mul8x8_ha_pipe_stage.sv
// rtl/mul8x8_ha_pipe_stage.sv - generic valid/ready register slice
// Accepts whenever empty or draining, so a full slice still sustains one transfer per cycle.
module mul8x8_ha_pipe_stage #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;

   assign in_ready = !valid_q || out_ready;

   // Data only moves on an accept, so a stalled or empty slice never picks up stray inputs.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (in_ready) begin
         valid_d = in_valid;
         if (in_valid) begin
            data_d = in_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;

endmodule

// File: rtl/unsigned_mul_8x8_ha_array_accum.sv
// rtl/unsigned_mul_8x8_ha_array_accum.sv - weights and sums HA-array rows into a saturated product
// S1 holds the two pair sums, S2 holds the saturated product; ovf_cnt counts delivered overflows.
module unsigned_mul_8x8_ha_array_accum
   import mul8x8_ha_pkg::*;
#(
   parameter int PROD_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [HA_B_W-1:0] ha_array_0_b,
   input  logic [HA_T_W-1:0] ha_array_0_t,
   input  logic [HA_B_W-1:0] ha_array_1_b,
   input  logic [HA_T_W-1:0] ha_array_1_t,
   input  logic [HA_B_W-1:0] ha_array_2_b,
   input  logic [HA_T_W-1:0] ha_array_2_t,
   input  logic [HA_B_W-1:0] ha_array_3_b,
   input  logic [HA_T_W-1:0] ha_array_3_t,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] prod,
   output logic              ovf,
   output logic [CNT_W-1:0]  ovf_cnt
);

   localparam int S1_W = 2 * PART_W;
   localparam int S2_W = PROD_W + 1;

   logic [ROW_W-1:0]  r0, r1, r2, r3;
   logic [PART_W-1:0] p01_d, p23_d, p01_q, p23_q;
   logic [S1_W-1:0]   s1_data;
   logic              s1_valid, s2_in_ready;
   logic [SUM_W-1:0]  sum_d;
   logic [PROD_W-1:0] prod_d;
   logic              ovf_d;
   logic [S2_W-1:0]   s2_data;
   logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;

   assign r0 = row_val(ha_array_0_b, ha_array_0_t);
   assign r1 = row_val(ha_array_1_b, ha_array_1_t);
   assign r2 = row_val(ha_array_2_b, ha_array_2_t);
   assign r3 = row_val(ha_array_3_b, ha_array_3_t);

   always_comb begin
      p01_d = PART_W'(r0) + (PART_W'(r1) << 2);
      p23_d = PART_W'(r2) + (PART_W'(r3) << 2);
   end

   mul8x8_ha_pipe_stage #(.DATA_W(S1_W)) u_s1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   ({p01_d, p23_d}),
      .out_valid (s1_valid),
      .out_ready (s2_in_ready),
      .out_data  (s1_data)
   );

   assign p01_q = s1_data[S1_W-1 -: PART_W];
   assign p23_q = s1_data[PART_W-1:0];

   // Bit SUM_W-1 is the only bit above the product range, so it alone flags saturation.
   always_comb begin
      sum_d  = SUM_W'(p01_q) + (SUM_W'(p23_q) << 4);
      ovf_d  = sum_d[SUM_W-1];
      prod_d = ovf_d ? '1 : sum_d[PROD_W-1:0];
   end

   mul8x8_ha_pipe_stage #(.DATA_W(S2_W)) u_s2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (s1_valid),
      .in_ready  (s2_in_ready),
      .in_data   ({ovf_d, prod_d}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (s2_data)
   );

   assign prod = s2_data[PROD_W-1:0];
   assign ovf  = s2_data[PROD_W];

   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if (out_valid && out_ready && ovf && !(&ovf_cnt_q)) begin
         ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_cnt_q <= '0;
      end else begin
         ovf_cnt_q <= ovf_cnt_d;
      end
   end

   assign ovf_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_array_accum.sv
// tb/tb_unsigned_mul_8x8_ha_array_accum.sv - scoreboard bench for the HA-array accumulator
// Driver pushes expected products on accept; a negedge monitor pops and compares on transfer.
module tb_unsigned_mul_8x8_ha_array_accum;

   typedef struct {
      logic [15:0] prod;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [6:0]  b [4];
   logic [8:0]  t [4];
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] prod;
   logic        ovf;
   logic [15:0] ovf_cnt;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_err = 0;
   int          n_popped = 0;
   bit          hold_pend = 0;
   logic [15:0] hold_prod;
   bit          saw_stall = 0;

   always #5 clk = ~clk;

   unsigned_mul_8x8_ha_array_accum dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .ha_array_0_b (b[0]),
      .ha_array_0_t (t[0]),
      .ha_array_1_b (b[1]),
      .ha_array_1_t (t[1]),
      .ha_array_2_b (b[2]),
      .ha_array_2_t (t[2]),
      .ha_array_3_b (b[3]),
      .ha_array_3_t (t[3]),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .prod         (prod),
      .ovf          (ovf),
      .ovf_cnt      (ovf_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_err++;
      $display("FAIL %s: bound expired at %0t", name, $time);
   endtask

   task automatic clear_rows();
      for (int k = 0; k < 4; k++) begin
         b[k] = '0;
         t[k] = '0;
      end
   endtask

   // Call at #1 after a posedge; returns at #1 after the accepting edge.
   task automatic send(input logic [15:0] ep, input logic eo, output int stalls);
      exp_t e;
      stalls   = 0;
      in_valid = 1'b1;
      while (1) begin
         @(negedge clk);
         if (in_ready) break;
         stalls++;
         if (stalls > 50) begin
            fail_now("send_timeout");
            in_valid = 1'b0;
            return;
         end
      end
      e.prod = ep;
      e.ovf  = eo;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int cyc = 0;
      while (sb_q.size() != 0) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc > 50) begin
            fail_now("drain_timeout");
            sb_q.delete();
            return;
         end
      end
   endtask

   function automatic int ref_sum();
      int s = 0;
      for (int k = 0; k < 4; k++) begin
         s += int'(t[k]) << (2 * k);
         s += int'(b[k]) << (2 * k + 2);
      end
      return s;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && in_valid && !in_ready) saw_stall = 1;
      if (rst_n && out_valid) begin
         if (hold_pend) chk("hold_prod", prod, hold_prod);
         if (out_ready) begin
            hold_pend = 0;
            if (sb_q.size() == 0) begin
               fail_now("unexpected_output");
            end else begin
               e = sb_q.pop_front();
               chk("prod", prod, e.prod);
               chk("ovf", ovf, e.ovf);
               n_popped++;
            end
         end else begin
            hold_pend = 1;
            hold_prod = prod;
         end
      end else begin
         if (rst_n && hold_pend) fail_now("valid_dropped");
         hold_pend = 0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int st;
      int tot;
      int base;
      int s;
      clear_rows();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_prod", prod, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_ovf_cnt", ovf_cnt, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);

      // zero rows with latency check
      send(16'd0, 1'b0, st);
      chk("lat_n", out_valid, 0);
      @(posedge clk);
      #1;
      chk("lat_n1", out_valid, 1);
      drain();

      t[0] = 9'h001;
      send(16'd1, 1'b0, st);
      clear_rows();
      b[1] = 7'h01;
      send(16'd16, 1'b0, st);
      clear_rows();
      t[3] = 9'h100;
      send(16'd16384, 1'b0, st);
      clear_rows();
      t[2] = 9'h003;
      b[2] = 7'h01;
      send(16'd112, 1'b0, st);
      clear_rows();
      t[0] = 9'h1FF;
      b[0] = 7'h7F;
      send(16'd1019, 1'b0, st);
      drain();
      chk("ovf_cnt_pre", ovf_cnt, 0);

      // saturation: sum 86615
      for (int k = 0; k < 4; k++) begin
         t[k] = 9'h1FF;
         b[k] = 7'h7F;
      end
      send(16'hFFFF, 1'b1, st);
      drain();
      @(posedge clk);
      #1;
      chk("ovf_cnt_sat", ovf_cnt, 1);

      // backpressure: out_ready low for cycles 2-5 of the stream
      clear_rows();
      saw_stall = 0;
      base = n_popped;
      fork
         begin
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join_none
      for (int i = 1; i <= 5; i++) begin
         t[1] = 9'(i);
         send(16'(4 * i), 1'b0, st);
      end
      drain();
      chk("bp_stall_seen", saw_stall, 1);
      chk("bp_count", n_popped - base, 5);

      // full rate: 20 random row sets
      base = n_popped;
      tot = 0;
      for (int i = 0; i < 20; i++) begin
         for (int k = 0; k < 4; k++) begin
            t[k] = 9'($urandom_range(511, 0));
            b[k] = 7'($urandom_range(127, 0));
         end
         s = ref_sum();
         if (s > 65535) send(16'hFFFF, 1'b1, st);
         else send(16'(s), 1'b0, st);
         tot += st;
      end
      in_valid = 1'b0;
      drain();
      chk("fr_no_stall", tot, 0);
      chk("fr_count", n_popped - base, 20);

      // reset with two results in flight
      clear_rows();
      out_ready = 1'b0;
      t[0] = 9'h002;
      send(16'd2, 1'b0, st);
      t[0] = 9'h003;
      send(16'd3, 1'b0, st);
      chk("ovf_cnt_before_rst", (ovf_cnt != 0), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_ovf_cnt", ovf_cnt, 0);
      sb_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      base = n_popped;
      t[0] = 9'h005;
      send(16'd5, 1'b0, st);
      drain();
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_count", n_popped - base, 1);
      chk("post_rst_idle", out_valid, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
